// File: rtl/io_defs.sv
// rtl/io_defs.sv - shared register map, bit indices and state encoding for the watchdog
//
// Purpose: constants shared by the watchdog supervisor and its helpers.
// Ports: none (package).

package io_defs;

  // Register offsets, selected by Address[2:1]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_KICK   = 2'd2;
  localparam logic [1:0] REG_CAUSE  = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN    = 0;
  localparam int CTRL_LOCK  = 1;
  localparam int CTRL_SWRST = 2;

  // CAUSE bit indices
  localparam int CAUSE_TIMEOUT = 0;
  localparam int CAUSE_BADKEY  = 1;
  localparam int CAUSE_SW      = 2;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_HOLD     = 2'd2
  } wdt_state_e;

  localparam logic [15:0] DEFAULT_KICK_KEY = 16'h5A5A;

endpackage

// File: rtl/wdt_prescaler.sv
// rtl/wdt_prescaler.sv - divide-by-PRESCALE tick generator with synchronous clear
//
// Purpose: while enabled, counts 0..PRESCALE-1 and flags a tick on the wrap cycle.
// Ports:
//   clock   in  system clock
//   resetn  in  synchronous active-low reset
//   enable  in  count this cycle
//   clear   in  restart the count from 0 (wins over enable)
//   tick    out high on the cycle the count wraps

module wdt_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] count_q, count_d;

  // tick is independent of clear so the parent can derive clear from its
  // own next-state logic without forming a combinational loop.
  assign tick = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? 16'd0 : count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wdt_reset_ctrl.sv
// rtl/wdt_reset_ctrl.sv - memory-mapped watchdog with keyed kicks and reset sequencer
//
// Purpose: programmable timeout counter, early-warning interrupt, fixed-length
// system reset pulse on timeout / bad key / software request, sticky cause reg.
// Ports:
//   clock          in   system clock
//   reset          in   synchronous active-low external/power-on reset
//   Select         in   chip select from the I/O address decoder
//   Read_enable    in   bus read strobe
//   Write_enable   in   bus write strobe
//   Address[2:0]   in   byte offset; [2:1] selects the register, [0] ignored
//   Write_data_in  in   16-bit write data
//   Read_data_out  out  registered read data (1-cycle latency, holds otherwise)
//   WDT_irq        out  early-warning interrupt, level
//   Sys_reset_out  out  active-high reset to CPU/peripherals

module wdt_reset_ctrl
  import io_defs::*;
#(
  parameter int unsigned RST_HOLD    = 4,
  parameter int unsigned PRESCALE    = 1,
  parameter logic [15:0] WARN_THRESH = 16'h00FF,
  parameter logic [15:0] KICK_KEY    = DEFAULT_KICK_KEY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Select,
  input  logic        Read_enable,
  input  logic        Write_enable,
  input  logic [2:0]  Address,
  input  logic [15:0] Write_data_in,
  output logic [15:0] Read_data_out,
  output logic        WDT_irq,
  output logic        Sys_reset_out
);

  wdt_state_e  state_q, state_d;
  logic [15:0] counter_q, counter_d;
  logic [15:0] reload_q, reload_d;
  logic        en_q, en_d;
  logic        lock_q, lock_d;
  logic [2:0]  cause_q, cause_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        sys_rst_q, sys_rst_d;

  logic        bus_wr, bus_rd;
  logic [1:0]  reg_sel;
  logic        wr_ctrl, wr_reload, wr_kick, wr_cause;
  logic        sw_req, en_req, dis_req, kick_ok, kick_bad;
  logic [2:0]  cause_set, cause_clr;
  logic        presc_en, presc_clear, tick;
  logic        unused_addr0;

  assign bus_wr       = Select & Write_enable;
  assign bus_rd       = Select & Read_enable;
  assign reg_sel      = Address[2:1];
  assign unused_addr0 = Address[0];

  assign wr_ctrl   = bus_wr && (reg_sel == REG_CTRL);
  assign wr_reload = bus_wr && (reg_sel == REG_RELOAD);
  assign wr_kick   = bus_wr && (reg_sel == REG_KICK);
  assign wr_cause  = bus_wr && (reg_sel == REG_CAUSE);

  assign sw_req   = wr_ctrl && Write_data_in[CTRL_SWRST];
  assign en_req   = wr_ctrl && !lock_q && Write_data_in[CTRL_EN];
  assign dis_req  = wr_ctrl && !lock_q && !Write_data_in[CTRL_EN];
  assign kick_ok  = wr_kick && (Write_data_in == KICK_KEY);
  assign kick_bad = wr_kick && (Write_data_in != KICK_KEY);

  assign presc_en = (state_q == ST_RUNNING);

  wdt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .resetn(reset),
    .enable(presc_en),
    .clear (presc_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    reload_d    = reload_q;
    en_d        = en_q;
    lock_d      = lock_q;
    hold_cnt_d  = hold_cnt_q;
    rdata_d     = rdata_q;
    presc_clear = 1'b0;
    cause_set   = 3'b000;
    cause_clr   = wr_cause ? Write_data_in[2:0] : 3'b000;

    // Reads return pre-write register contents.
    if (bus_rd) begin
      case (reg_sel)
        REG_CTRL:   rdata_d = {14'd0, lock_q, en_q};
        REG_RELOAD: rdata_d = reload_q;
        REG_CAUSE:  rdata_d = {13'd0, cause_q};
        default:    rdata_d = 16'd0;
      endcase
    end

    // Configuration writes are dropped while the reset pulse is being issued.
    if (state_q != ST_HOLD) begin
      if (wr_ctrl) begin
        lock_d = lock_q | Write_data_in[CTRL_LOCK];
        if (!lock_q) begin
          en_d = Write_data_in[CTRL_EN];
        end
      end
      if (wr_reload && !lock_q) begin
        reload_d = Write_data_in;
      end
    end

    case (state_q)
      ST_DISABLED: begin
        if (sw_req) begin
          cause_set[CAUSE_SW] = 1'b1;
          state_d             = ST_HOLD;
        end else if (en_req) begin
          counter_d   = reload_q;
          presc_clear = 1'b1;
          state_d     = ST_RUNNING;
        end
      end

      ST_RUNNING: begin
        // Explicit bus requests take precedence over the tick of the same cycle.
        if (sw_req) begin
          cause_set[CAUSE_SW] = 1'b1;
          state_d             = ST_HOLD;
        end else if (kick_bad) begin
          cause_set[CAUSE_BADKEY] = 1'b1;
          state_d                 = ST_HOLD;
        end else if (dis_req) begin
          state_d = ST_DISABLED;
        end else if (kick_ok) begin
          counter_d   = reload_q;
          presc_clear = 1'b1;
        end else if (tick) begin
          if (counter_q == 16'd0) begin
            cause_set[CAUSE_TIMEOUT] = 1'b1;
            state_d                  = ST_HOLD;
          end else begin
            counter_d = counter_q - 16'd1;
          end
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == 4'(RST_HOLD - 1)) begin
          if (lock_q) begin
            // A locked watchdog always restarts; EN is forced so CTRL reads
            // stay consistent with the running state.
            counter_d   = reload_q;
            presc_clear = 1'b1;
            en_d        = 1'b1;
            state_d     = ST_RUNNING;
          end else begin
            en_d    = 1'b0;
            state_d = ST_DISABLED;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_DISABLED;
      end
    endcase

    if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
      hold_cnt_d = 4'd0;
    end

    // A new cause set wins over a same-cycle write-1-to-clear.
    cause_d   = (cause_q & ~cause_clr) | cause_set;
    irq_d     = (state_d == ST_RUNNING) && (counter_d <= WARN_THRESH);
    sys_rst_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_DISABLED;
      counter_q  <= 16'hFFFF;
      reload_q   <= 16'hFFFF;
      en_q       <= 1'b0;
      lock_q     <= 1'b0;
      cause_q    <= 3'b000;
      hold_cnt_q <= 4'd0;
      rdata_q    <= 16'd0;
      irq_q      <= 1'b0;
      sys_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      reload_q   <= reload_d;
      en_q       <= en_d;
      lock_q     <= lock_d;
      cause_q    <= cause_d;
      hold_cnt_q <= hold_cnt_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      sys_rst_q  <= sys_rst_d;
    end
  end

  assign Read_data_out = rdata_q;
  assign WDT_irq       = irq_q;
  assign Sys_reset_out = sys_rst_q;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// tb/tb_wdt_reset_ctrl.sv - self-checking bench for the watchdog reset controller

module tb_wdt_reset_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        Select = 1'b0;
  logic        Read_enable = 1'b0;
  logic        Write_enable = 1'b0;
  logic [2:0]  Address = 3'd0;
  logic [15:0] Write_data_in = 16'd0;

  logic [15:0] rd0, rd1;
  logic        irq0, irq1, rst0, rst1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  // dut0 uses the directed-test parameters; dut1 exercises a slow prescaler.
  wdt_reset_ctrl #(.RST_HOLD(4), .PRESCALE(1), .WARN_THRESH(16'd2), .KICK_KEY(16'h5A5A)) dut0 (
    .clock(clock), .reset(reset), .Select(Select), .Read_enable(Read_enable),
    .Write_enable(Write_enable), .Address(Address), .Write_data_in(Write_data_in),
    .Read_data_out(rd0), .WDT_irq(irq0), .Sys_reset_out(rst0));

  wdt_reset_ctrl #(.RST_HOLD(2), .PRESCALE(3), .WARN_THRESH(16'd5), .KICK_KEY(16'h5A5A)) dut1 (
    .clock(clock), .reset(reset), .Select(Select), .Read_enable(Read_enable),
    .Write_enable(Write_enable), .Address(Address), .Write_data_in(Write_data_in),
    .Read_data_out(rd1), .WDT_irq(irq1), .Sys_reset_out(rst1));

  function automatic int p_pre(input int k);  return (k == 0) ? 1 : 3; endfunction
  function automatic int p_hold(input int k); return (k == 0) ? 4 : 2; endfunction
  function automatic int p_warn(input int k); return (k == 0) ? 2 : 5; endfunction

  // Behavioural model: mode 0 = off, 1 = counting, 2 = issuing reset pulse.
  int          m_mode[2], m_cnt[2], m_reload[2], m_left[2], m_phase[2];
  bit          m_en[2], m_lock[2];
  bit [2:0]    m_cause[2];
  logic [15:0] m_rd[2];

  task automatic model_edge(input int k);
    bit          wr, rd, was_locked, to_hold;
    int          a;
    logic [15:0] wd;
    bit [2:0]    newc;
    wr = Select && Write_enable;
    rd = Select && Read_enable;
    a  = int'(Address[2:1]);
    wd = Write_data_in;
    if (!reset) begin
      m_mode[k] = 0; m_cnt[k] = 16'hFFFF; m_reload[k] = 16'hFFFF; m_left[k] = 0;
      m_phase[k] = 0; m_en[k] = 0; m_lock[k] = 0; m_cause[k] = 0; m_rd[k] = 0;
      return;
    end
    if (rd) begin
      if (a == 0)      m_rd[k] = {14'd0, m_lock[k], m_en[k]};
      else if (a == 1) m_rd[k] = m_reload[k][15:0];
      else if (a == 3) m_rd[k] = {13'd0, m_cause[k]};
      else             m_rd[k] = 16'd0;
    end
    newc = 3'b000;
    if (m_mode[k] == 2) begin
      m_left[k] = m_left[k] - 1;
      if (m_left[k] == 0) begin
        if (m_lock[k]) begin
          m_mode[k] = 1; m_cnt[k] = m_reload[k]; m_phase[k] = 0; m_en[k] = 1;
        end else begin
          m_mode[k] = 0; m_en[k] = 0;
        end
      end
    end else begin
      was_locked = m_lock[k];
      to_hold = 0;
      if (wr && a == 0 && wd[2]) begin
        newc[2] = 1; to_hold = 1;
      end else if (m_mode[k] == 1 && wr && a == 2 && wd != 16'h5A5A) begin
        newc[1] = 1; to_hold = 1;
      end
      if (wr && a == 0) begin
        if (!was_locked) m_en[k] = wd[0];
        if (wd[1]) m_lock[k] = 1;
      end
      if (wr && a == 1 && !was_locked) m_reload[k] = int'(wd);
      if (!to_hold) begin
        if (m_mode[k] == 0) begin
          if (wr && a == 0 && !was_locked && wd[0]) begin
            m_mode[k] = 1; m_cnt[k] = m_reload[k]; m_phase[k] = 0;
          end
        end else begin
          if (wr && a == 0 && !was_locked && !wd[0]) begin
            m_mode[k] = 0;
          end else if (wr && a == 2) begin
            m_cnt[k] = m_reload[k]; m_phase[k] = 0;
          end else begin
            m_phase[k] = m_phase[k] + 1;
            if (m_phase[k] == p_pre(k)) begin
              m_phase[k] = 0;
              if (m_cnt[k] == 0) begin
                newc[0] = 1; to_hold = 1;
              end else begin
                m_cnt[k] = m_cnt[k] - 1;
              end
            end
          end
        end
      end
      if (to_hold) begin
        m_mode[k] = 2; m_left[k] = p_hold(k);
      end
    end
    if (wr && a == 3) m_cause[k] = m_cause[k] & ~wd[2:0];
    m_cause[k] = m_cause[k] | newc;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("rd0",  rd0,  m_rd[0]);
      chk("irq0", {15'd0, irq0}, {15'd0, (m_mode[0] == 1) && (m_cnt[0] <= p_warn(0))});
      chk("rst0", {15'd0, rst0}, {15'd0, m_mode[0] == 2});
      chk("rd1",  rd1,  m_rd[1]);
      chk("irq1", {15'd0, irq1}, {15'd0, (m_mode[1] == 1) && (m_cnt[1] <= p_warn(1))});
      chk("rst1", {15'd0, rst1}, {15'd0, m_mode[1] == 2});
    end
  end

  task automatic step(input bit s, input bit re, input bit we, input logic [2:0] ad,
                      input logic [15:0] wd);
    Select = s; Read_enable = re; Write_enable = we; Address = ad; Write_data_in = wd;
    @(posedge clock);
    #1;
    model_edge(0);
    model_edge(1);
  endtask

  task automatic idle();                                  step(0, 0, 0, 3'd0, 16'd0); endtask
  task automatic wr_reg(input logic [2:0] ad, input logic [15:0] wd); step(1, 0, 1, ad, wd); endtask
  task automatic rd_lit(input logic [2:0] ad, input logic [15:0] exp, input string name);
    step(1, 1, 0, ad, 16'd0);
    chk(name, rd0, exp);
  endtask

  int hi, n;
  bit found;

  initial begin
    // Reset and register defaults
    reset = 1'b0;
    idle(); idle();
    chk_on = 1'b1;
    reset = 1'b1;
    chk("rst_after_reset", {15'd0, rst0}, 16'd0);
    chk("irq_after_reset", {15'd0, irq0}, 16'd0);
    rd_lit(3'd0, 16'h0000, "ctrl_reset");
    rd_lit(3'd2, 16'hFFFF, "reload_reset");
    rd_lit(3'd6, 16'h0000, "cause_reset");

    // Timeout with RELOAD=4, no kicks
    wr_reg(3'd2, 16'h0004);
    wr_reg(3'd0, 16'h0001);
    for (int i = 1; i <= 9; i++) begin
      idle();
      chk($sformatf("to_irq_%0d", i), {15'd0, irq0}, {15'd0, (i >= 2) && (i <= 4)});
      chk($sformatf("to_rst_%0d", i), {15'd0, rst0}, {15'd0, (i >= 5) && (i <= 8)});
    end
    rd_lit(3'd6, 16'h0001, "cause_timeout");
    rd_lit(3'd0, 16'h0000, "ctrl_after_timeout");
    wr_reg(3'd6, 16'h0007);
    rd_lit(3'd6, 16'h0000, "cause_cleared");

    // Regular valid kicks keep it alive
    wr_reg(3'd2, 16'h0010);
    wr_reg(3'd0, 16'h0001);
    for (int i = 0; i < 100; i++) begin
      if (i % 8 == 0) wr_reg(3'd4, 16'h5A5A);
      else idle();
      chk("kick_irq", {15'd0, irq0}, 16'd0);
      chk("kick_rst", {15'd0, rst0}, 16'd0);
    end
    wr_reg(3'd0, 16'h0000);

    // Bad key
    wr_reg(3'd0, 16'h0001);
    wr_reg(3'd4, 16'h1234);
    chk("badkey_hold", {15'd0, rst0}, 16'd1);
    idle(); idle(); idle(); idle();
    chk("badkey_hold_end", {15'd0, rst0}, 16'd0);
    rd_lit(3'd6, 16'h0002, "cause_badkey");
    wr_reg(3'd6, 16'h0002);
    rd_lit(3'd6, 16'h0000, "cause_badkey_clr");
    rd_lit(3'd0, 16'h0000, "ctrl_after_badkey");

    // Lock: EN/RELOAD writes ignored, restart after timeout
    wr_reg(3'd2, 16'h0004);
    wr_reg(3'd0, 16'h0003);
    wr_reg(3'd0, 16'h0000);
    wr_reg(3'd2, 16'h0001);
    rd_lit(3'd2, 16'h0004, "lock_reload");
    rd_lit(3'd0, 16'h0003, "lock_ctrl");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle();
      if (rst0) found = 1'b1;
    end
    chk("lock_hold_seen", {15'd0, found}, 16'd1);
    hi = 1;
    for (int i = 0; i < 20 && rst0; i++) begin
      idle();
      if (rst0) hi++;
    end
    chk("lock_hold_len", 16'(hi), 16'd4);
    chk("lock_exit_irq", {15'd0, irq0}, 16'd0);
    n = 0;
    for (int i = 0; i < 10 && !irq0; i++) begin
      idle();
      n++;
    end
    chk("lock_restart_cnt", 16'(n), 16'd2);
    rd_lit(3'd0, 16'h0003, "lock_ctrl_after");

    // External reset in the middle of HOLD
    wr_reg(3'd0, 16'h0004);
    chk("swrst_hold", {15'd0, rst0}, 16'd1);
    idle();
    reset = 1'b0;
    idle();
    reset = 1'b1;
    chk("midhold_rst", {15'd0, rst0}, 16'd0);
    chk("midhold_irq", {15'd0, irq0}, 16'd0);
    rd_lit(3'd0, 16'h0000, "midhold_ctrl");
    rd_lit(3'd2, 16'hFFFF, "midhold_reload");
    rd_lit(3'd6, 16'h0000, "midhold_cause");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [2:0] ad;
      logic [15:0] wd;
      bit s;
      r  = $urandom_range(0, 99);
      s  = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if (r < 40) begin
        step(s, 0, 0, 3'($urandom_range(0, 7)), 16'($urandom));
      end else if (r < 55) begin
        step(s, 1, 0, 3'($urandom_range(0, 7)), 16'd0);
      end else if (r < 75) begin
        wd = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h5A5A;
        ad = {2'd2, 1'($urandom_range(0, 1))};
        step(s, 0, 1, ad, wd);
      end else if (r < 85) begin
        ad = {2'd1, 1'($urandom_range(0, 1))};
        step(s, 0, 1, ad, 16'($urandom_range(0, 24)));
      end else if (r < 95) begin
        wd = 16'd0;
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = ($urandom_range(0, 29) == 0);
        wd[2] = ($urandom_range(0, 24) == 0);
        ad = {2'd0, 1'($urandom_range(0, 1))};
        step(s, 0, 1, ad, wd);
      end else begin
        ad = {2'd3, 1'($urandom_range(0, 1))};
        step(s, 0, 1, ad, 16'($urandom_range(0, 7)));
      end
    end
    reset = 1'b1;
    idle();
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
